// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_SAT_EN to clamp the result to 0 when a < b.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_diff_load;

    assign w_accept  = start && (r_state != StShift);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    // r_res holds the WIDTH-1 most recent difference bits; the final bit completes the word.
    assign w_shift   = {w_d, r_res};

`ifdef SERIAL_SUBTRACTOR_SAT_EN
    assign w_diff_load = w_br_next ? '0 : w_shift;
`else
    assign w_diff_load = w_shift;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StShift;
            StShift: if (w_last) w_state_next = StDone;
            StDone:  w_state_next = start ? StShift : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        busy = (r_state == StShift);
        done = (r_state == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == StShift) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_res <= w_shift[WIDTH-1:1];
            r_br  <= w_br_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff   <= w_diff_load;
                r_borrow <= w_br_next;
            end
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH 4, 8 and 16.
// Latency is counted in rising edges, the accepting edge included.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        start4 = 1'b0;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic        busy4, busy8, busy16;
    logic        done4, done8, done16;
    logic        borrow4, borrow8, borrow16;
    logic [3:0]  diff4;
    logic [7:0]  diff8;
    logic [15:0] diff16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a[3:0]), .b(b[3:0]),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
    );
    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a[7:0]), .b(b[7:0]),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
    );
    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a), .b(b),
        .busy(busy16), .done(done16), .diff(diff16), .borrow_out(borrow16)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_diff(input int w, input logic [15:0] av,
                                             input logic [15:0] bv);
        logic [31:0] mask;
        logic [31:0] m;
        mask = (32'd1 << w) - 32'd1;
        m = ({16'd0, av} - {16'd0, bv}) & mask;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
        if ((av & mask[15:0]) < (bv & mask[15:0])) m = '0;
`endif
        return m;
    endfunction

    function automatic logic sel_done(input int w);
        return (w == 4) ? done4 : (w == 8) ? done8 : done16;
    endfunction

    function automatic logic sel_busy(input int w);
        return (w == 4) ? busy4 : (w == 8) ? busy8 : busy16;
    endfunction

    task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                          output int lat, output logic [15:0] dv, output logic bo);
        @(negedge clk);
        a = av;
        b = bv;
        case (w)
            4:       start4 = 1'b1;
            8:       start8 = 1'b1;
            default: start16 = 1'b1;
        endcase
        @(posedge clk);
        lat = 1;
        #1;
        start4 = 1'b0;
        start8 = 1'b0;
        start16 = 1'b0;
        check_eq("busy_after_accept", {31'd0, sel_busy(w)}, 32'd1);
        while (!sel_done(w) && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        dv = (w == 4) ? {12'd0, diff4} : (w == 8) ? {8'd0, diff8} : diff16;
        bo = (w == 4) ? borrow4 : (w == 8) ? borrow8 : borrow16;
    endtask

    task automatic model_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                            input string tag);
        int          lat;
        logic [15:0] dv;
        logic        bo;
        logic [15:0] mask;
        mask = 16'((32'd1 << w) - 32'd1);
        run_op(w, av, bv, lat, dv, bo);
        check_eq({tag, "_lat"}, lat, w + 1);
        check_eq({tag, "_diff"}, {16'd0, dv}, exp_diff(w, av, bv));
        check_eq({tag, "_borrow"}, {31'd0, bo}, {31'd0, (av & mask) < (bv & mask)});
    endtask

    logic [7:0] va [4] = '{8'hC3, 8'h10, 8'h00, 8'h7F};
    logic [7:0] vb [4] = '{8'h3C, 8'h20, 8'hFF, 8'h7F};

    initial begin
        int          lat;
        int          cnt;
        logic [15:0] dv;
        logic        bo;
        logic        seen_done;
        logic [31:0] prev;

        #2;
        check_eq("rst_busy8", {31'd0, busy8}, 32'd0);
        check_eq("rst_done8", {31'd0, done8}, 32'd0);
        check_eq("rst_diff8", {24'd0, diff8}, 32'd0);
        check_eq("rst_borrow8", {31'd0, borrow8}, 32'd0);
        check_eq("rst_diff16", {16'd0, diff16}, 32'd0);
        check_eq("rst_done4", {31'd0, done4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0x5A - 0x23 = 0x37
        run_op(8, 16'h5A, 16'h23, lat, dv, bo);
        check_eq("basic_lat", lat, 9);
        check_eq("basic_diff", {16'd0, dv}, 32'h37);
        check_eq("basic_borrow", {31'd0, bo}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", {31'd0, done8}, 32'd0);
        check_eq("hold_diff_idle", {24'd0, diff8}, 32'h37);

        run_op(8, 16'h00, 16'h01, lat, dv, bo);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
        check_eq("under_diff", {16'd0, dv}, 32'h00);
`else
        check_eq("under_diff", {16'd0, dv}, 32'hFF);
`endif
        check_eq("under_borrow", {31'd0, bo}, 32'd1);

        run_op(8, 16'hA5, 16'hA5, lat, dv, bo);
        check_eq("equal_diff", {16'd0, dv}, 32'h00);
        check_eq("equal_borrow", {31'd0, bo}, 32'd0);

        run_op(8, 16'h00, 16'hFF, lat, dv, bo);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
        check_eq("zero_minus_max_diff", {16'd0, dv}, 32'h00);
`else
        check_eq("zero_minus_max_diff", {16'd0, dv}, 32'h01);
`endif
        check_eq("zero_minus_max_borrow", {31'd0, bo}, 32'd1);

        run_op(8, 16'hFF, 16'h00, lat, dv, bo);
        check_eq("max_minus_zero_diff", {16'd0, dv}, 32'hFF);
        check_eq("max_minus_zero_borrow", {31'd0, bo}, 32'd0);

        // Back-to-back with start held high; operands scrambled during SHIFT.
        prev = exp_diff(8, 16'hFF, 16'h00);
        @(negedge clk);
        a = {8'd0, va[0]};
        b = {8'd0, vb[0]};
        start8 = 1'b1;
        @(posedge clk);
        #1;
        cnt = 1;
        for (int k = 0; k < 4; k++) begin
            check_eq("b2b_busy", {31'd0, busy8}, 32'd1);
            check_eq("b2b_hold_diff", {24'd0, diff8}, prev);
            while (!done8 && cnt < 30) begin
                a = 16'($urandom);
                b = 16'($urandom);
                @(posedge clk);
                #1;
                cnt++;
            end
            check_eq("b2b_period", cnt, 9);
            prev = exp_diff(8, {8'd0, va[k]}, {8'd0, vb[k]});
            check_eq("b2b_diff", {24'd0, diff8}, prev);
            check_eq("b2b_borrow", {31'd0, borrow8}, {31'd0, va[k] < vb[k]});
            if (k < 3) begin
                a = {8'd0, va[k+1]};
                b = {8'd0, vb[k+1]};
                @(posedge clk);
                #1;
                cnt = 1;
            end else begin
                start8 = 1'b0;
            end
        end

        // Leave a nonzero borrow/diff in place, then abort mid-SHIFT.
        run_op(8, 16'h00, 16'h01, lat, dv, bo);
        @(negedge clk);
        a = 16'h5A;
        b = 16'h23;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", {31'd0, busy8}, 32'd0);
        check_eq("abort_done", {31'd0, done8}, 32'd0);
        check_eq("abort_diff", {24'd0, diff8}, 32'd0);
        check_eq("abort_borrow", {31'd0, borrow8}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            seen_done |= done8;
        end
        check_eq("abort_no_done", {31'd0, seen_done}, 32'd0);
        run_op(8, 16'h10, 16'h10, lat, dv, bo);
        check_eq("post_abort_lat", lat, 9);
        check_eq("post_abort_diff", {16'd0, dv}, 32'h00);
        check_eq("post_abort_borrow", {31'd0, bo}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                model_op(4, 16'(i), 16'(j), "w4");
            end
        end

        model_op(16, 16'h1234, 16'h0FFF, "w16_a");
        model_op(16, 16'h0000, 16'hFFFF, "w16_b");
        model_op(16, 16'h8000, 16'h8000, "w16_c");
        model_op(16, 16'hFFFF, 16'h0001, "w16_d");
        model_op(16, 16'h0001, 16'h0002, "w16_e");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
